rx_cntrl: RTL

Receive-side controller for the SPI test link; the counterpart of the periodic transmit controller.
- Monitors the 16-bit word/strobe pair delivered by the SPI receiver.
- Checks each word against the expected test pattern and checks the strobe period against the nominal frame period.
- Acquires and tracks lock, detects loss of frames, and keeps saturating status counters for link bring-up and ILA/debug readout.

---
 rtl/rx_cntrl_pkg.sv | 23 ++
 rtl/rx_ivl_timer.sv | 36 +++
 rtl/rx_cntrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/rx_cntrl_pkg.sv
// Shared types, default constants and helpers for the SPI receive-side controller.
package rx_cntrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2,
    LOST   = 2'd3
  } rx_state_t;

  localparam logic [15:0] DEF_EXP_DATA = 16'd1937;
  localparam int          DEF_PERIOD   = 2097152;
  localparam int          DEF_TOL      = 4;
  localparam int          DEF_LOCK_N   = 2;
  localparam int          DEF_IVL_W    = 22;

  // Increment that sticks at max_val; narrower counters pass a zero-extended value
  // and their own ceiling, then truncate the result.
  function automatic logic [15:0] sat_inc(input logic [15:0] val, input logic [15:0] max_val);
    return (val == max_val) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/rx_ivl_timer.sv
// Measures the spacing between dv strobes and flags in-window intervals and timeouts.
module rx_ivl_timer
  import rx_cntrl_pkg::*;
#(
  parameter int PERIOD = DEF_PERIOD,
  parameter int TOL    = DEF_TOL,
  parameter int IVL_W  = DEF_IVL_W
) (
  input  logic clk,
  input  logic reset,
  input  logic dv,
  output logic ivl_ok,
  output logic tmo_hit
);

  localparam logic [IVL_W-1:0] IVL_LO  = IVL_W'(PERIOD - TOL);
  localparam logic [IVL_W-1:0] IVL_HI  = IVL_W'(PERIOD + TOL);
  localparam logic [IVL_W-1:0] IVL_TMO = IVL_W'(PERIOD + TOL + 1);

  logic [IVL_W-1:0] ivl;

  // Restart at 1 on each strobe so that at the next strobe ivl equals the elapsed cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ivl <= '0;
    end else if (dv) begin
      ivl <= IVL_W'(1);
    end else if (!(&ivl)) begin
      ivl <= ivl + IVL_W'(1);
    end
  end

  assign ivl_ok  = (ivl >= IVL_LO) && (ivl <= IVL_HI);
  assign tmo_hit = (ivl == IVL_TMO);

endmodule

// File: rtl/rx_cntrl.sv
// Receive-side test-link controller: pattern/period checking, lock tracking and status counters.
module rx_cntrl
  import rx_cntrl_pkg::*;
#(
  parameter logic [15:0] EXP_DATA = DEF_EXP_DATA,
  parameter int          PERIOD   = DEF_PERIOD,
  parameter int          TOL      = DEF_TOL,
  parameter int          LOCK_N   = DEF_LOCK_N,
  parameter int          IVL_W    = DEF_IVL_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_data,
  input  logic        dv,
  output logic [15:0] rx_data_q,
  output logic        locked,
  output logic        lost,
  output logic        frame_ok,
  output logic [15:0] frame_cnt,
  output logic [7:0]  err_cnt,
  output logic [7:0]  tmo_cnt
);

  rx_state_t  state;
  logic [7:0] run;
  logic [7:0] run_next;
  logic       ivl_ok;
  logic       tmo_hit;
  logic       tracking;
  logic       frame_good;

  rx_ivl_timer #(
    .PERIOD (PERIOD),
    .TOL    (TOL),
    .IVL_W  (IVL_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .dv      (dv),
    .ivl_ok  (ivl_ok),
    .tmo_hit (tmo_hit)
  );

  assign tracking   = (state == ACQ) || (state == LOCKED);
  assign frame_good = (rx_data == EXP_DATA) && (!tracking || ivl_ok);
  assign run_next   = run + 8'd1;

  // Lock state machine with registered status outputs; a strobe always takes priority over a timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      run       <= '0;
      rx_data_q <= '0;
      locked    <= 1'b0;
      lost      <= 1'b0;
      frame_ok  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      tmo_cnt   <= '0;
    end else begin
      frame_ok <= 1'b0;
      if (dv) begin
        rx_data_q <= rx_data;
        if (frame_good) begin
          frame_ok  <= 1'b1;
          frame_cnt <= sat_inc(frame_cnt, 16'hFFFF);
          case (state)
            IDLE, LOST: begin
              run <= 8'd1;
              if (LOCK_N == 1) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                state <= ACQ;
              end
            end
            ACQ: begin
              run <= run_next;
              if (run_next == 8'(LOCK_N)) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end
            end
            LOCKED: begin
              state <= LOCKED;
            end
            default: begin
              state  <= IDLE;
              locked <= 1'b0;
            end
          endcase
        end else begin
          err_cnt <= 8'(sat_inc({8'h00, err_cnt}, 16'h00FF));
          if (tracking) begin
            state  <= IDLE;
            run    <= '0;
            locked <= 1'b0;
          end
        end
      end else if (tmo_hit && tracking) begin
        tmo_cnt <= 8'(sat_inc({8'h00, tmo_cnt}, 16'h00FF));
        lost    <= 1'b1;
        run     <= '0;
        state   <= LOST;
        locked  <= 1'b0;
      end
    end
  end

endmodule
